fifo_rd_arbiter: RTL and testbench

//  Shares the single read port of the async FIFO read side among NREQ consumers in the rclk domain.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr_i, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int unsigned    cand;
        logic [IDW-1:0] cidx;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cidx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cidx = cand[IDW-1:0];
            if (!any_o && req_i[cidx]) begin
                any_o          = 1'b1;
                idx_o          = cidx;
                onehot_o[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one FIFO read port among NREQ consumers (rclk domain).
// Optional empty-stall abort enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_W    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*BURST_W-1:0]      req_len,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_rdata,
    output logic                         fifo_rd,
    output logic [NREQ-1:0]              gnt,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    output logic [clog2_min1(NREQ)-1:0]  out_id,
    input  logic                         out_ready,
    output logic [NREQ-1:0]              done,
    output logic                         aborted
);

    localparam int IDW = clog2_min1(NREQ);

    if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fifo_rd_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        id_q, id_d, rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [BURST_W-1:0]    rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  abort_q, abort_d;
    logic                  stall_hit;
    logic                  drain_fire;
    logic [NREQ-1:0]       pick_onehot;
    logic [IDW-1:0]        pick_idx;
    logic                  pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge rclk) begin
        if (rrst || state_q != XFER || fifo_rd) stall_q <= '0;
        else if (fifo_empty)                    stall_q <= stall_q + 1'b1;
    end

    // Fires on the TIMEOUT-th consecutive empty cycle so DRAIN follows immediately.
    assign stall_hit = (state_q == XFER) && fifo_empty && (stall_q == STALL_W'(TIMEOUT - 1));
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        int unsigned len_base;
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        rem_d    = rem_q;
        data_d   = data_q;
        valid_d  = valid_q;
        abort_d  = abort_q;
        len_base = 32'(pick_idx) * BURST_W;
        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (pick_any) begin
                    state_d = XFER;
                    id_d    = pick_idx;
                    gnt_d   = pick_onehot;
                    rem_d   = req_len[len_base +: BURST_W];
                end
            end
            XFER: begin
                if (fifo_rd) begin
                    data_d  = fifo_rdata;
                    valid_d = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == '0) state_d = DRAIN;
                end else begin
                    if (out_ready) valid_d = 1'b0;
                    if (stall_hit) begin
                        state_d = DRAIN;
                        abort_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_fire) begin
                    valid_d  = 1'b0;
                    abort_d  = 1'b0;
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd    = (state_q == XFER) && !fifo_empty && (!valid_q || out_ready);
        drain_fire = (state_q == DRAIN) && (!valid_q || out_ready);
        gnt        = (state_q != IDLE) ? gnt_q : '0;
        done       = drain_fire ? gnt_q : '0;
        aborted    = drain_fire && abort_q;
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed scoreboard bench for fifo_rd_arbiter with a behavioural FIFO model.
module tb_fifo_rd_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic        rclk;
    logic        rrst;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_rd;
    logic [3:0]  gnt;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_id;
    logic        out_ready;
    logic [3:0]  done;
    logic        aborted;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         base;
    int         n;
    logic [3:0] done_s;
    logic       abort_s;

    fifo_rd_arbiter #(
        .NREQ       (4),
        .DATA_WIDTH (8),
        .BURST_W    (4),
        .TIMEOUT    (8)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .req        (req),
        .req_len    (req_len),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .gnt        (gnt),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .done       (done),
        .aborted    (aborted)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic tick();
        logic do_pop;
        exp_t e;
        #1;
        do_pop = fifo_rd && !fifo_empty;
        check("rd_while_empty", {31'd0, fifo_rd && fifo_empty}, 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", {24'd0, out_data}, {24'd0, e.data});
                check("sb_id", {30'd0, out_id}, {30'd0, e.id});
                check("sb_gnt", {28'd0, gnt}, 32'd1 << e.id);
            end
        end
        done_s  = done;
        abort_s = aborted;
        if (|done) done_cnt++;
        @(posedge rclk);
        #1;
        if (do_pop) begin
            fifo_q.delete(0);
            refresh();
        end
    endtask

    task automatic run_until_done(input string tag, input int budget, input logic [3:0] exp_done,
                                  input logic exp_ab, output int cnt);
        cnt    = 0;
        done_s = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cnt++;
            if (|done_s) break;
        end
        check({tag, "_done"}, {28'd0, done_s}, {28'd0, exp_done});
        check({tag, "_aborted"}, {31'd0, abort_s}, {31'd0, exp_ab});
    endtask

    task automatic do_reset();
        rrst      = 1'b1;
        req       = '0;
        req_len   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rrst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        refresh();
    endtask

    initial begin
        rrst      = 1'b1;
        req       = '0;
        req_len   = '0;
        out_ready = 1'b1;
        refresh();
        do_reset();
        #1;
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_aborted", {31'd0, aborted}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_id", {30'd0, out_id}, 32'd0);

        // 1: single requester, 4-word burst from an 8-word FIFO
        for (int k = 0; k < 8; k++) fifo_q.push_back(8'(8'hA0 + k));
        refresh();
        for (int k = 0; k < 4; k++) exp_q.push_back({2'd0, 8'(8'hA0 + k)});
        req_len[3:0] = 4'd3;
        req          = 4'b0001;
        base         = done_cnt;
        tick();
        #1;
        check("t1_gnt", {28'd0, gnt}, 32'b0001);
        check("t1_first_rd", {31'd0, fifo_rd}, 32'd1);
        req = '0;
        run_until_done("t1", 20, 4'b0001, 1'b0, n);
        check("t1_cycles", n, 5);
        tick();
        tick();
        check("t1_done_pulses", done_cnt - base, 1);
        check("t1_sb_left", exp_q.size(), 0);
        check("t1_fifo_left", fifo_q.size(), 4);

        // 2: all request, len 0 each -> strict rotation 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 8; k++) fifo_q.push_back(8'(k));
        refresh();
        for (int g = 0; g < 5; g++) exp_q.push_back({2'(g % 4), 8'(g)});
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            run_until_done("t2", 10, 4'(1 << (g % 4)), 1'b0, n);
        end
        req = '0;
        tick();
        #1;
        check("t2_idle_gnt", {28'd0, gnt}, 32'd0);
        check("t2_sb_left", exp_q.size(), 0);
        check("t2_fifo_left", fifo_q.size(), 3);

        // 3: FIFO runs dry after the first word, refilled later
        do_reset();
        fifo_q.push_back(8'hB0);
        refresh();
        for (int k = 0; k < 3; k++) exp_q.push_back({2'd2, 8'(8'hB0 + k)});
        req_len[11:8] = 4'd2;
        req           = 4'b0100;
        tick();
        tick();
        req = '0;
        for (int k = 0; k < 6; k++) tick();
        #1;
        check("t3_stall_rd", {31'd0, fifo_rd}, 32'd0);
        check("t3_stall_gnt", {28'd0, gnt}, 32'b0100);
        check("t3_stall_sb", exp_q.size(), 2);
        fifo_q.push_back(8'hB1);
        fifo_q.push_back(8'hB2);
        refresh();
        run_until_done("t3", 20, 4'b0100, 1'b0, n);
        check("t3_sb_left", exp_q.size(), 0);
        check("t3_fifo_left", fifo_q.size(), 0);

        // 4: consumer back-pressure for 3 cycles mid-burst
        do_reset();
        for (int k = 0; k < 6; k++) fifo_q.push_back(8'(8'hC0 + k));
        refresh();
        for (int k = 0; k < 4; k++) exp_q.push_back({2'd1, 8'(8'hC0 + k)});
        req_len[7:4] = 4'd3;
        req          = 4'b0010;
        tick();
        req = '0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t4_hold_data", {24'd0, out_data}, 32'hC1);
            check("t4_hold_rd", {31'd0, fifo_rd}, 32'd0);
        end
        out_ready = 1'b1;
        run_until_done("t4", 20, 4'b0010, 1'b0, n);
        check("t4_sb_left", exp_q.size(), 0);
        check("t4_fifo_left", fifo_q.size(), 2);

        // 5: reset in the middle of a burst
        do_reset();
        for (int k = 0; k < 8; k++) fifo_q.push_back(8'(8'hD0 + k));
        refresh();
        exp_q.push_back({2'd3, 8'hD0});
        exp_q.push_back({2'd3, 8'hD1});
        req_len[15:12] = 4'd3;
        req            = 4'b1000;
        tick();
        tick();
        tick();
        base = done_cnt;
        rrst = 1'b1;
        req  = '0;
        tick();
        rrst = 1'b0;
        #1;
        check("t5_gnt", {28'd0, gnt}, 32'd0);
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rd", {31'd0, fifo_rd}, 32'd0);
        check("t5_done", {28'd0, done}, 32'd0);
        check("t5_no_done_pulse", done_cnt - base, 0);
        check("t5_sb_partial", exp_q.size(), 0);
        req_len = '0;
        exp_q.push_back({2'd0, fifo_q[0]});
        exp_q.push_back({2'd3, fifo_q[1]});
        req = 4'b1001;
        run_until_done("t5a", 10, 4'b0001, 1'b0, n);
        run_until_done("t5b", 10, 4'b1000, 1'b0, n);
        req = '0;
        tick();
        check("t5_sb_left", exp_q.size(), 0);

        // 7: maximum length field gives 16 words without wrapping
        do_reset();
        for (int k = 0; k < 20; k++) fifo_q.push_back(8'(8'h40 + k));
        refresh();
        for (int k = 0; k < 16; k++) exp_q.push_back({2'd1, 8'(8'h40 + k)});
        req_len[7:4] = 4'd15;
        req          = 4'b0010;
        tick();
        req = '0;
        run_until_done("t7", 40, 4'b0010, 1'b0, n);
        check("t7_cycles", n, 17);
        check("t7_sb_left", exp_q.size(), 0);
        check("t7_fifo_left", fifo_q.size(), 4);

        // 6: empty stall with only one word available
        do_reset();
        fifo_q.push_back(8'hE0);
        refresh();
        exp_q.push_back({2'd0, 8'hE0});
        req_len[3:0] = 4'd3;
        req          = 4'b0001;
        base         = done_cnt;
        tick();
        req = '0;
`ifdef FIFO_RD_TIMEOUT_EN
        run_until_done("t6", 30, 4'b0001, 1'b1, n);
        check("t6_cycles", n, 10);
        check("t6_sb_left", exp_q.size(), 0);
`else
        for (int k = 0; k < 20; k++) tick();
        #1;
        check("t6_hold_gnt", {28'd0, gnt}, 32'b0001);
        check("t6_hold_rd", {31'd0, fifo_rd}, 32'd0);
        check("t6_hold_aborted", {31'd0, aborted}, 32'd0);
        check("t6_no_done", done_cnt - base, 0);
        for (int k = 1; k < 4; k++) begin
            fifo_q.push_back(8'(8'hE0 + k));
            exp_q.push_back({2'd0, 8'(8'hE0 + k)});
        end
        refresh();
        run_until_done("t6", 20, 4'b0001, 1'b0, n);
        check("t6_sb_left", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
